// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the write-port count and the byte-merge helpers used by storage and bypass.
package regfile_pkg;

    localparam int NUM_WR = 2;

    // Helpers work on a wide container so that any legal WIDTH fits.
    // Callers zero-extend their operands and take the low WIDTH bits back.
    localparam int MAX_W = 512;
    localparam int MAX_B = MAX_W / 8;

    typedef logic [MAX_W-1:0] wide_t;
    typedef logic [MAX_B-1:0] wide_be_t;

    function automatic wide_t byte_merge(
        input wide_t    old_w,
        input wide_t    new_w,
        input wide_be_t be
    );
        wide_t res;
        for (int b = 0; b < MAX_B; b++) begin
            res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

    // Port 0 is applied first so port 1 wins any byte both ports enable.
    function automatic wide_t wr_resolve(
        input wide_t    old_w,
        input wide_t    d0,
        input wide_be_t be0,
        input logic     hit0,
        input wide_t    d1,
        input wide_be_t be1,
        input logic     hit1
    );
        wide_t res;
        res = old_w;
        if (hit0) res = byte_merge(res, d0, be0);
        if (hit1) res = byte_merge(res, d1, be1);
        return res;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port with write-first bypass and zero-register gating.
// Ports: clk/reset, i_mem (storage view), i_wr_* (both write ports),
//        i_rd_en/i_rd_addr request, o_rd_data/o_rd_valid one cycle later.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 16,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH),
    localparam int BW       = WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        i_mem [DEPTH],
    input  logic [NUM_WR-1:0]       i_wr_en,
    input  logic [NUM_WR*AW-1:0]    i_wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] i_wr_data,
    input  logic [NUM_WR*BW-1:0]    i_wr_be,
    input  logic                    i_rd_en,
    input  logic [AW-1:0]           i_rd_addr,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic                    o_rd_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] w_word;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_zero;
    wide_t            w_res;
    logic             w_unused_hi;

    assign w_old  = i_mem[i_rd_addr];
    assign w_hit0 = i_wr_en[0] && (i_wr_addr[0 +: AW] == i_rd_addr);
    assign w_hit1 = i_wr_en[1] && (i_wr_addr[AW +: AW] == i_rd_addr);

    // Same merge as the array update, so bypass sees the post-write word.
    assign w_res = wr_resolve(
        wide_t'(w_old),
        wide_t'(i_wr_data[0 +: WIDTH]),
        wide_be_t'(i_wr_be[0 +: BW]),
        w_hit0,
        wide_t'(i_wr_data[WIDTH +: WIDTH]),
        wide_be_t'(i_wr_be[BW +: BW]),
        w_hit1
    );

    assign w_unused_hi = ^w_res[MAX_W-1:WIDTH];

    assign w_zero = (ZERO_REG != 0) && (i_rd_addr == '0);
    assign w_word = w_zero ? '0 : w_res[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_rd_en;
            if (i_rd_en) r_data <= w_word;
        end
    end

    assign o_rd_data  = r_data;
    assign o_rd_valid = r_valid;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: DEPTH x WIDTH, two byte-enabled write ports,
// NUM_RD registered read ports with write-first bypass, optional zero reg.
// Ports: clk, reset (async high), wr_en/wr_addr/wr_data/wr_be (2 ports),
//        rd_en/rd_addr (NUM_RD ports), rd_data/rd_valid (1-cycle latency).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 16,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH),
    localparam int BW       = WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic [NUM_WR*BW-1:0]    wr_be,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_valid
);

    logic [WIDTH-1:0] r_mem  [DEPTH];
    logic [WIDTH-1:0] w_next [DEPTH];
    logic [DEPTH-1:0] w_unused_row;

    wide_t    w_d0;
    wide_t    w_d1;
    wide_be_t w_be0;
    wide_be_t w_be1;

    assign w_d0  = wide_t'(wr_data[0 +: WIDTH]);
    assign w_d1  = wide_t'(wr_data[WIDTH +: WIDTH]);
    assign w_be0 = wide_be_t'(wr_be[0 +: BW]);
    assign w_be1 = wide_be_t'(wr_be[BW +: BW]);

    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        logic  w_h0;
        logic  w_h1;
        wide_t w_res;

        assign w_h0  = wr_en[0] && (wr_addr[0 +: AW] == AW'(i));
        assign w_h1  = wr_en[1] && (wr_addr[AW +: AW] == AW'(i));
        assign w_res = wr_resolve(wide_t'(r_mem[i]),
                                  w_d0, w_be0, w_h0,
                                  w_d1, w_be1, w_h1);

        assign w_next[i]       = w_res[WIDTH-1:0];
        assign w_unused_row[i] = ^w_res[MAX_W-1:WIDTH];
    end

    // With ZERO_REG the entry 0 flop only ever sees reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(ZERO_REG != 0 && i == 0)) r_mem[i] <= w_next[i];
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        regfile_rd_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .clk        (clk),
            .reset      (reset),
            .i_mem      (r_mem),
            .i_wr_en    (wr_en),
            .i_wr_addr  (wr_addr),
            .i_wr_data  (wr_data),
            .i_wr_be    (wr_be),
            .i_rd_en    (rd_en[r]),
            .i_rd_addr  (rd_addr[r*AW +: AW]),
            .o_rd_data  (rd_data[r*WIDTH +: WIDTH]),
            .o_rd_valid (rd_valid[r])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default build plus a ZERO_REG,
// DEPTH=32, NUM_RD=3 build, table vectors and a read-result scoreboard.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  m_we;
    logic [7:0]  m_wa;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic [1:0]  m_re;
    logic [7:0]  m_ra;
    logic [31:0] m_rd;
    logic [1:0]  m_rv;

    logic [1:0]  z_we;
    logic [9:0]  z_wa;
    logic [31:0] z_wd;
    logic [3:0]  z_be;
    logic [2:0]  z_re;
    logic [14:0] z_ra;
    logic [47:0] z_rd;
    logic [2:0]  z_rv;

    regfile_mp u_dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (m_we),
        .wr_addr  (m_wa),
        .wr_data  (m_wd),
        .wr_be    (m_be),
        .rd_en    (m_re),
        .rd_addr  (m_ra),
        .rd_data  (m_rd),
        .rd_valid (m_rv)
    );

    regfile_mp #(
        .WIDTH    (16),
        .DEPTH    (32),
        .NUM_RD   (3),
        .ZERO_REG (1)
    ) u_dz (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (z_we),
        .wr_addr  (z_wa),
        .wr_data  (z_wd),
        .wr_be    (z_be),
        .rd_en    (z_re),
        .rd_addr  (z_ra),
        .rd_data  (z_rd),
        .rd_valid (z_rv)
    );

    typedef struct {
        logic [1:0]  we;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  be0;
        logic [1:0]  be1;
        logic [1:0]  re;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [15:0] x0;
        logic [15:0] x1;
        logic [1:0]  xv;
    } vec_t;

    typedef struct {
        int          due;
        int          dut;
        int          port;
        logic [15:0] d;
        logic        v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   nvec  = 0;
    int   nfail = 0;

    function automatic logic [15:0] act_d(int dut, int p);
        if (dut == 0) return m_rd[p*16 +: 16];
        return z_rd[p*16 +: 16];
    endfunction

    function automatic logic act_v(int dut, int p);
        if (dut == 0) return m_rv[p];
        return z_rv[p];
    endfunction

    task automatic push(int dut, int p, logic [15:0] d, logic v, string n);
        exp_t e;
        e.due  = cyc + 1;
        e.dut  = dut;
        e.port = p;
        e.d    = d;
        e.v    = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        logic [15:0] ad;
        logic av;
        @(posedge clk);
        #1;
        cyc++;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e  = q.pop_front();
            ad = act_d(e.dut, e.port);
            av = act_v(e.dut, e.port);
            nvec++;
            if (e.due != cyc || ad !== e.d || av !== e.v) begin
                nfail++;
                $display("FAIL %s dut%0d port%0d: got data=%h valid=%b, expected data=%h valid=%b",
                         e.name, e.dut, e.port, ad, av, e.d, e.v);
            end
        end
    endtask

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic drive_m(logic [1:0] we, logic [3:0] a0, logic [3:0] a1,
                           logic [15:0] d0, logic [15:0] d1,
                           logic [1:0] be0, logic [1:0] be1,
                           logic [1:0] re, logic [3:0] r0, logic [3:0] r1);
        m_we = we;
        m_wa = {a1, a0};
        m_wd = {d1, d0};
        m_be = {be1, be0};
        m_re = re;
        m_ra = {r1, r0};
    endtask

    task automatic idle_z();
        z_we = '0;
        z_wa = '0;
        z_wd = '0;
        z_be = '0;
        z_re = '0;
        z_ra = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{2'b01, 4'd3, 4'd0, 16'hABCD, 16'h0000, 2'b11, 2'b00,
                    2'b01, 4'd3, 4'd0, 16'hABCD, 16'h0000, 2'b01};
        tbl[1]  = '{2'b01, 4'd3, 4'd0, 16'h1234, 16'h0000, 2'b01, 2'b00,
                    2'b10, 4'd0, 4'd3, 16'hABCD, 16'hAB34, 2'b10};
        tbl[2]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00, 2'b00,
                    2'b11, 4'd3, 4'd3, 16'hAB34, 16'hAB34, 2'b11};
        tbl[3]  = '{2'b11, 4'd5, 4'd5, 16'h1111, 16'h2222, 2'b11, 2'b10,
                    2'b00, 4'd0, 4'd0, 16'hAB34, 16'hAB34, 2'b00};
        tbl[4]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00, 2'b00,
                    2'b11, 4'd5, 4'd0, 16'h2211, 16'h0000, 2'b11};
        tbl[5]  = '{2'b01, 4'd7, 4'd0, 16'h5A5A, 16'h0000, 2'b11, 2'b00,
                    2'b10, 4'd0, 4'd7, 16'h2211, 16'h5A5A, 2'b10};
        tbl[6]  = '{2'b11, 4'd2, 4'd2, 16'h00C3, 16'h9999, 2'b01, 2'b00,
                    2'b11, 4'd2, 4'd7, 16'h00C3, 16'h5A5A, 2'b11};
        tbl[7]  = '{2'b11, 4'd9, 4'd9, 16'hAAAA, 16'h5555, 2'b11, 2'b11,
                    2'b11, 4'd9, 4'd9, 16'h5555, 16'h5555, 2'b11};
        tbl[8]  = '{2'b11, 4'd4, 4'd9, 16'h4444, 16'h7700, 2'b11, 2'b10,
                    2'b11, 4'd9, 4'd4, 16'h7755, 16'h4444, 2'b11};
        tbl[9]  = '{2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00, 2'b00,
                    2'b11, 4'd2, 4'd5, 16'h00C3, 16'h2211, 2'b11};
        tbl[10] = '{2'b10, 4'd0, 4'd15, 16'h0000, 16'hC0DE, 2'b00, 2'b11,
                    2'b01, 4'd15, 4'd0, 16'hC0DE, 16'h2211, 2'b01};

        drive_m(2'b11, 4'd1, 4'd2, 16'hFFFF, 16'hFFFF, 2'b11, 2'b11,
                2'b11, 4'd1, 4'd2);
        idle_z();
        z_re = 3'b111;
        tick();
        tick();
        chk("reset_rd_data", 64'(m_rd), 64'h0);
        chk("reset_rd_valid", 64'(m_rv), 64'h0);
        chk("reset_z_rd_data", 64'(z_rd), 64'h0);
        chk("reset_z_rd_valid", 64'(z_rv), 64'h0);
        z_re = '0;
        #3 reset = 1'b0;

        for (int a = 0; a < 16; a++) begin
            drive_m(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00, 2'b00,
                    2'b11, 4'(a), 4'(15 - a));
            push(0, 0, 16'h0000, 1'b1, "reset_sweep");
            push(0, 1, 16'h0000, 1'b1, "reset_sweep");
            tick();
        end
        drive_m(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00, 2'b00,
                2'b00, 4'd0, 4'd0);
        push(0, 0, 16'h0000, 1'b0, "valid_drop");
        push(0, 1, 16'h0000, 1'b0, "valid_drop");
        tick();

        for (int i = 0; i < 11; i++) begin
            drive_m(tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
                    tbl[i].be0, tbl[i].be1, tbl[i].re, tbl[i].r0, tbl[i].r1);
            push(0, 0, tbl[i].x0, tbl[i].xv[0], $sformatf("vec%0d", i));
            push(0, 1, tbl[i].x1, tbl[i].xv[1], $sformatf("vec%0d", i));
            tick();
        end
        drive_m(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00, 2'b00,
                2'b00, 4'd0, 4'd0);

        z_we = 2'b11;
        z_wa = {5'd0, 5'd0};
        z_wd = {16'hFFFF, 16'hFFFF};
        z_be = 4'b1111;
        z_re = 3'b111;
        z_ra = {5'd0, 5'd0, 5'd0};
        for (int p = 0; p < 3; p++) push(1, p, 16'h0000, 1'b1, "zero_bypass");
        tick();
        z_we = 2'b01;
        z_wa = {5'd0, 5'd31};
        z_wd = {16'h0000, 16'h1357};
        z_be = 4'b0011;
        z_re = 3'b111;
        z_ra = {5'd0, 5'd0, 5'd31};
        push(1, 0, 16'h1357, 1'b1, "z_addr31");
        push(1, 1, 16'h0000, 1'b1, "zero_later");
        push(1, 2, 16'h0000, 1'b1, "zero_later");
        tick();
        idle_z();
        z_re = 3'b100;
        z_ra = {5'd31, 5'd0, 5'd0};
        push(1, 0, 16'h1357, 1'b0, "z_hold");
        push(1, 1, 16'h0000, 1'b0, "z_hold");
        push(1, 2, 16'h1357, 1'b1, "z_port2");
        tick();
        idle_z();

        drive_m(2'b01, 4'd9, 4'd0, 16'hBEEF, 16'h0, 2'b11, 2'b00,
                2'b00, 4'd0, 4'd0);
        tick();
        drive_m(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00, 2'b00,
                2'b01, 4'd9, 4'd0);
        push(0, 0, 16'hBEEF, 1'b1, "pre_reset_read");
        tick();
        drive_m(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00, 2'b00,
                2'b11, 4'd9, 4'd9);
        #2 reset = 1'b1;
        #1;
        chk("async_clr_data", 64'(m_rd), 64'h0);
        chk("async_clr_valid", 64'(m_rv), 64'h0);
        tick();
        #3 reset = 1'b0;
        drive_m(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00, 2'b00,
                2'b01, 4'd9, 4'd0);
        push(0, 0, 16'h0000, 1'b1, "post_reset_addr9");
        push(0, 1, 16'h0000, 1'b0, "post_reset_p1");
        tick();
        drive_m(2'b01, 4'd9, 4'd0, 16'h0F0F, 16'h0, 2'b11, 2'b00,
                2'b01, 4'd9, 4'd0);
        push(0, 0, 16'h0F0F, 1'b1, "rewrite_addr9");
        tick();
        drive_m(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00, 2'b00,
                2'b00, 4'd0, 4'd0);
        push(0, 0, 16'h0F0F, 1'b0, "hold_after_idle");
        tick();
        tick();

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            nfail++;
            $display("FAIL %s: expected result never compared", e.name);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the next generation of the team's 16x16 register file. It provides DEPTH words of WIDTH bits, two write ports with byte enables, and NUM_RD registered read ports with write-first bypass. An optional hardwired-zero register is available. It sits between the datapath decode stage and the execute stage and supplies operands one cycle after the read request.

Parameters:
WIDTH, 16, word width in bits; must be a multiple of 8.
DEPTH, 16, number of registers; power of two, at least 2.
NUM_RD, 2, number of independent read ports, 1 to 4.
ZERO_REG, 0, 1 makes register 0 read as zero and ignore writes.
AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high; clears all state.
wr_en  in  2  per-write-port enable; bit p controls port p.
wr_addr  in  2*AW  write addresses; port p is at [p*AW +: AW].
wr_data  in  2*WIDTH  write data; port p is at [p*WIDTH +: WIDTH].
wr_be  in  2*(WIDTH/8)  byte enables per write port; 1 means write that byte.
rd_en  in  NUM_RD  per-read-port request.
rd_addr  in  NUM_RD*AW  read addresses; port r is at [r*AW +: AW].
rd_data  out  NUM_RD*WIDTH  registered read data.
rd_valid  out  NUM_RD  high for one cycle after an accepted read.

Behaviour:
- Reset (asynchronous assert, any time):
  - all DEPTH registers become 0;
  - rd_data becomes 0; rd_valid becomes 0.
  - Deassertion takes effect on the next rising clk edge. A write or read presented in the cycle reset is high is discarded.
- Write, per port p, on a rising edge with wr_en[p]=1:
  - each byte b with wr_be[p][b]=1 takes wr_data byte b;
  - other bytes hold their value.
  - wr_en[p]=1 with wr_be all zero changes nothing.
- Write-port collision (both ports enabled on the same address):
  - bytes enabled on only one port take that port's data;
  - bytes enabled on both ports take port 1's data (port 1 has priority).
  - No error is flagged.
- ZERO_REG=1:
  - writes to address 0 are ignored;
  - reads of address 0 return 0, including through the bypass path.
- Read, per port r, on a rising edge with rd_en[r]=1:
  - rd_data[r] is loaded with the word at rd_addr[r];
  - rd_valid[r]=1 in the following cycle. Latency is exactly 1 cycle.
- Read with rd_en[r]=0:
  - rd_valid[r] drops to 0;
  - rd_data[r] holds its last value. It is not zeroed.
- Write-first bypass: a read and a write to the same address in the same cycle returns the post-write word. This is the merged byte result after collision resolution, computed the same way the array is updated.
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- There is no stall or backpressure. Every enabled request is serviced in its cycle.

Decomposition:
- Shared package regfile_pkg:
  - constant NUM_WR=2;
  - function byte_merge(old, new, be) returning the byte-masked WIDTH word;
  - function for the collision-resolved write word.
- Sub-module regfile_rd_port:
  - contains one read port's address mux, bypass compare against both write ports, zero-register gating, and the output/valid registers;
  - instantiated NUM_RD times in a generate loop.
- The top level holds the storage array and the write logic.

Test Plan:
- Reset with defaults: after reset, read addresses 0..15 on both ports -> every rd_data=0x0000, rd_valid=1 exactly one cycle after each rd_en.
- Byte enables: write addr 3 data 0xABCD be=11, then write addr 3 data 0x1234 be=01 -> read addr 3 returns 0xAB34.
- Collision: port 0 writes addr 5 0x1111 be=11 and port 1 writes addr 5 0x2222 be=10 in the same cycle -> read addr 5 returns 0x2211.
- Bypass: addr 7 holds 0x0000; in one cycle port 0 writes addr 7 0x5A5A and read port 1 reads addr 7 -> next cycle rd_data[1]=0x5A5A, rd_valid[1]=1.
- ZERO_REG=1, DEPTH=32, NUM_RD=3: write addr 0 0xFFFF while reading addr 0 on all ports -> all rd_data=0 in the next cycle and in later reads.
- Reset mid-operation: write addr 9 0xBEEF, then assert reset asynchronously between edges while rd_en=1 -> rd_data and rd_valid clear immediately; after release, read addr 9 returns 0x0000; rd_en=0 -> rd_valid=0 and rd_data holds.
